div_iter: RTL and testbench

//  Parametrised multi-cycle restoring divider for the EX stage of the 5-stage pipeline.

---
 rtl/div_iter.sv | 134 +++++++++++++
 tb/tb_div_iter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per clock,
// signed (DIV) or unsigned (DIVU), returning {remainder, quotient}.
//
// state  | meaning
// FREE   | idle, waiting for start_i; outputs held at zero
// BYZERO | divisor was zero, result forced to zero
// ON     | iterating, one quotient bit per cycle
// END    | result presented on result_o with ready_o until start_i drops
module div_iter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   dvd;
    logic [DATA_W-1:0]   dvs;
    logic [DATA_W-1:0]   rem;
    logic                neg_q;
    logic                neg_r;
    logic [2*DATA_W-1:0] res;

    logic                sign1;
    logic                sign2;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   q_next;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   q_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        sign1 = signed_div_i & opdata1_i[DATA_W-1];
        sign2 = signed_div_i & opdata2_i[DATA_W-1];
        mag1  = sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
        mag2  = sign2 ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    // The dividend register doubles as the quotient: its MSB feeds the
    // partial remainder while the new quotient bit enters at the LSB.
    always_comb begin
        diff     = {rem, dvd[DATA_W-1]} - {1'b0, dvs};
        q_next   = {dvd[DATA_W-2:0], ~diff[DATA_W]};
        rem_next = diff[DATA_W] ? {rem[DATA_W-2:0], dvd[DATA_W-1]} : diff[DATA_W-1:0];
        q_fix    = neg_q ? (~q_next + 1'b1) : q_next;
        rem_fix  = neg_r ? (~rem_next + 1'b1) : rem_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            res      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            state <= S_ON;
                            dvd   <= mag1;
                            dvs   <= mag2;
                            rem   <= '0;
                            cnt   <= '0;
                            neg_r <= sign1;
                            neg_q <= sign1 ^ sign2;
                        end
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state <= S_FREE;
                    end else begin
                        res   <= '0;
                        state <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state <= S_FREE;
                    end else begin
                        dvd <= q_next;
                        rem <= rem_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            state <= S_END;
                            res   <= {rem_fix, q_fix};
                        end
                    end
                end
                S_END: begin
                    if (start_i) begin
                        ready_o  <= 1'b1;
                        result_o <= res;
                    end else begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= S_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed scenarios plus randomized ops
// compared against a plain-arithmetic division model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    logic        signed_div8 = 1'b0;
    logic [7:0]  op1_8 = '0;
    logic [7:0]  op2_8 = '0;
    logic        start8 = 1'b0;
    logic        annul8 = 1'b0;
    logic [15:0] result8;
    logic        ready8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_iter #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1),
        .opdata2_i(op2), .start_i(start), .annul_i(annul),
        .result_o(result), .ready_o(ready)
    );

    div_iter #(.DATA_W(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div8), .opdata1_i(op1_8),
        .opdata2_i(op2_8), .start_i(start8), .annul_i(annul8),
        .result_o(result8), .ready_o(ready8)
    );

    // Reference: truncating division, remainder follows dividend sign, x/0 -> 0.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Runs one op with start held until ready, holds one extra cycle with
    // scrambled operands, then drops start. Returns latency 0 on timeout.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat,
                          output logic [64:0] held, output logic [64:0] dropped);
        signed_div = s;
        op1 = a;
        op2 = b;
        start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = n;
                break;
            end
        end
        res = result;
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~s;
        @(posedge clk); #1;
        held = {ready, result};
        start = 1'b0;
        @(posedge clk); #1;
        dropped = {ready, result};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
        n_cmp++;
        if (result !== 64'd0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++;
        if (ready8 !== 1'b0 || result8 !== 16'd0) begin
            n_err++; $display("FAIL reset_w8 got %b/%h want 0/0", ready8, result8);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_divu();
        logic [63:0] res;
        logic [64:0] held, dropped;
        int lat;
        run_op(1'b0, 32'd100, 32'd7, res, lat, held, dropped);
        n_cmp++;
        if (res !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_100_7 got %h want %h", res, {32'd2, 32'd14}); end
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL divu_latency got %0d want 33", lat); end
        n_cmp++;
        if (held !== {1'b1, 32'd2, 32'd14}) begin n_err++; $display("FAIL divu_hold got %h want %h", held, {1'b1, 32'd2, 32'd14}); end
        n_cmp++;
        if (dropped !== 65'd0) begin n_err++; $display("FAIL divu_drop got %h want 0", dropped); end
    endtask

    task automatic test_div_signed();
        logic [63:0] res;
        logic [64:0] held, dropped;
        int lat;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, held, dropped);
        n_cmp++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_err++; $display("FAIL div_m7_2 got %h want %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        end
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat, held, dropped);
        n_cmp++;
        if (res !== {32'd1, 32'hFFFF_FFFD}) begin
            n_err++; $display("FAIL div_7_m2 got %h want %h", res, {32'd1, 32'hFFFF_FFFD});
        end
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL div_latency got %0d want 33", lat); end
    endtask

    task automatic test_byzero();
        logic [63:0] res;
        logic [64:0] held, dropped;
        int lat;
        for (int s = 0; s < 2; s++) begin
            run_op(s[0], 32'd12345, 32'd0, res, lat, held, dropped);
            n_cmp++;
            if (lat !== 2) begin n_err++; $display("FAIL byzero_latency s=%0d got %0d want 2", s, lat); end
            n_cmp++;
            if (res !== 64'd0) begin n_err++; $display("FAIL byzero_result s=%0d got %h want 0", s, res); end
            n_cmp++;
            if (dropped !== 65'd0) begin n_err++; $display("FAIL byzero_drop s=%0d got %h want 0", s, dropped); end
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        logic [64:0] held, dropped;
        int lat;
        logic saw_ready;
        saw_ready = 1'b0;
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            saw_ready |= ready;
        end
        annul = 1'b1;
        op1 = 32'd9;
        op2 = 32'd3;
        @(posedge clk); #1;
        saw_ready |= ready;
        annul = 1'b0;
        n_cmp++;
        if (saw_ready !== 1'b0) begin n_err++; $display("FAIL annul_ready got 1 want 0"); end
        run_op(1'b0, 32'd9, 32'd3, res, lat, held, dropped);
        n_cmp++;
        if (res !== {32'd0, 32'd3}) begin n_err++; $display("FAIL annul_restart got %h want %h", res, {32'd0, 32'd3}); end
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL annul_restart_latency got %0d want 33", lat); end
    endtask

    task automatic test_rst_mid();
        logic [63:0] res;
        logic [64:0] held, dropped;
        int lat;
        logic got_ready;
        signed_div = 1'b0;
        op1 = 32'd500;
        op2 = 32'd7;
        start = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL rst_on got %b/%h want 0/0", ready, result);
        end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        op1 = 32'd6;
        op2 = 32'd4;
        start = 1'b1;
        got_ready = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (ready) begin got_ready = 1'b1; break; end
        end
        n_cmp++;
        if (got_ready !== 1'b1) begin n_err++; $display("FAIL rst_end_reach got 0 want 1"); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL rst_end got %b/%h want 0/0", ready, result);
        end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(1'b1, 32'hFFFF_FF9C, 32'd9, res, lat, held, dropped);
        n_cmp++;
        if (res !== ref_div(1'b1, 32'hFFFF_FF9C, 32'd9)) begin
            n_err++; $display("FAIL rst_fresh got %h want %h", res, ref_div(1'b1, 32'hFFFF_FF9C, 32'd9));
        end
    endtask

    task automatic test_overflow();
        logic [63:0] res;
        logic [64:0] held, dropped;
        int lat;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, held, dropped);
        n_cmp++;
        if (res !== {32'd0, 32'h8000_0000}) begin
            n_err++; $display("FAIL overflow got %h want %h", res, {32'd0, 32'h8000_0000});
        end
    endtask

    task automatic test_w8();
        int lat;
        logic [15:0] res;
        signed_div8 = 1'b0;
        op1_8 = 8'd200;
        op2_8 = 8'd3;
        start8 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (ready8) begin lat = n; break; end
        end
        res = result8;
        start8 = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (res !== {8'd2, 8'd66}) begin n_err++; $display("FAIL w8_200_3 got %h want %h", res, {8'd2, 8'd66}); end
        n_cmp++;
        if (lat !== 9) begin n_err++; $display("FAIL w8_latency got %0d want 9", lat); end
        n_cmp++;
        if (ready8 !== 1'b0) begin n_err++; $display("FAIL w8_drop got %b want 0", ready8); end
    endtask

    task automatic test_random();
        logic [63:0] res, exp;
        logic [64:0] held, dropped;
        logic [31:0] a, b;
        logic s;
        int lat, exp_lat;
        for (int i = 0; i < 300; i++) begin
            s = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = $urandom_range(1, 50); end
                1: begin a = $urandom_range(0, 1000); b = $urandom_range(0, 1000); end
                2: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
                3: begin a = $urandom; b = 32'd0; end
                4: begin a = -($urandom_range(1, 5000)); b = -($urandom_range(1, 60)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            exp = ref_div(s, a, b);
            exp_lat = (b == 0) ? 2 : 33;
            run_op(s, a, b, res, lat, held, dropped);
            n_cmp++;
            if (res !== exp) begin
                n_err++; $display("FAIL rand_%0d s=%0b a=%h b=%h got %h want %h", i, s, a, b, res, exp);
            end
            n_cmp++;
            if (lat !== exp_lat) begin
                n_err++; $display("FAIL rand_lat_%0d got %0d want %0d", i, lat, exp_lat);
            end
            n_cmp++;
            if (held !== {1'b1, exp} || dropped !== 65'd0) begin
                n_err++; $display("FAIL rand_hold_%0d got %h/%h want %h/0", i, held, dropped, {1'b1, exp});
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_byzero();
        test_annul();
        test_rst_mid();
        test_overflow();
        test_w8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
